// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl_if
//  Description : Button inputs and timer-control outputs of the stopwatch
//                controller. The lap-capture signals exist only when
//                STOPWATCH_CTRL_LAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface stopwatch_ctrl_if #(
    parameter int DATA_WIDTH = 16
);
    logic btn_ss;
    logic btn_clr;
    logic start;
    logic stop;
    logic clear;
    logic running;
`ifdef STOPWATCH_CTRL_LAP_EN
    logic                  btn_lap;
    logic [DATA_WIDTH-1:0] count_in;
    logic [DATA_WIDTH-1:0] lap_count;
    logic                  lap_valid;

    modport master (
        output btn_ss, btn_clr, btn_lap, count_in,
        input  start, stop, clear, running, lap_count, lap_valid
    );
    modport slave (
        input  btn_ss, btn_clr, btn_lap, count_in,
        output start, stop, clear, running, lap_count, lap_valid
    );
`else
    modport master (
        output btn_ss, btn_clr,
        input  start, stop, clear, running
    );
    modport slave (
        input  btn_ss, btn_clr,
        output start, stop, clear, running
    );
`endif
endinterface
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_ctrl
//  Description : Start/stop/clear controller for a stopwatch timer. Raw
//                buttons are synchronised and debounced, press events drive
//                an IDLE/RUN/PAUSE FSM that emits registered control pulses.
//                Define STOPWATCH_CTRL_LAP_EN to add the lap-capture button.
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
    parameter int DB_CYCLES  = 4,
    parameter int DATA_WIDTH = 16
) (
    input wire              clk,
    input wire              reset,
    stopwatch_ctrl_if.slave bus
);

    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;
`ifdef STOPWATCH_CTRL_LAP_EN
    localparam int BTN_LAP = 2;
    localparam int NB      = 3;
`else
    localparam int NB      = 2;
`endif

    logic [NB-1:0] w_raw;
    logic [NB-1:0] w_press;

    assign w_raw[BTN_SS]  = bus.btn_ss;
    assign w_raw[BTN_CLR] = bus.btn_clr;
`ifdef STOPWATCH_CTRL_LAP_EN
    assign w_raw[BTN_LAP] = bus.btn_lap;
`endif

    // ------------------------------------------------------------------
    // Per-button synchroniser + debouncer + rising-edge detector
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NB; i++) begin : g_btn
        logic          r_sync_a;
        logic          r_sync_b;
        logic          r_level;
        logic          r_level_q;
        logic [CW-1:0] r_cnt;

        // Level flips once the synchronised input has disagreed with it for
        // DB_CYCLES consecutive samples; any agreeing sample restarts the count.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sync_a  <= 1'b0;
                r_sync_b  <= 1'b0;
                r_level   <= 1'b0;
                r_level_q <= 1'b0;
                r_cnt     <= '0;
            end else begin
                r_sync_a  <= w_raw[i];
                r_sync_b  <= r_sync_a;
                r_level_q <= r_level;
                if (r_sync_b == r_level) begin
                    r_cnt <= '0;
                end else if (r_cnt == CNT_LAST) begin
                    r_level <= ~r_level;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // Only presses produce events; releases are ignored.
        assign w_press[i] = r_level & ~r_level_q;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_start_nxt;
    logic   w_stop_nxt;
    logic   w_clear_nxt;
    logic   r_start;
    logic   r_stop;
    logic   r_clear;
    logic   r_running;

    // Next state and pulse decode; clear takes priority over start/stop.
    always_comb begin
        w_state_nxt = r_state;
        w_start_nxt = 1'b0;
        w_stop_nxt  = 1'b0;
        w_clear_nxt = 1'b0;
        if (w_press[BTN_CLR]) begin
            w_state_nxt = ST_IDLE;
            w_clear_nxt = 1'b1;
            w_stop_nxt  = (r_state == ST_RUN);
        end else if (w_press[BTN_SS]) begin
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSE;
                w_stop_nxt  = 1'b1;
            end else begin
                w_state_nxt = ST_RUN;
                w_start_nxt = 1'b1;
            end
        end
    end

    // State register and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_start   <= 1'b0;
            r_stop    <= 1'b0;
            r_clear   <= 1'b0;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start   <= w_start_nxt;
            r_stop    <= w_stop_nxt;
            r_clear   <= w_clear_nxt;
            r_running <= (w_state_nxt == ST_RUN);
        end
    end

    assign bus.start   = r_start;
    assign bus.stop    = r_stop;
    assign bus.clear   = r_clear;
    assign bus.running = r_running;

`ifdef STOPWATCH_CTRL_LAP_EN
    // ------------------------------------------------------------------
    // Lap capture
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_lap_count;
    logic                  r_lap_valid;

    // Capture the live count on a lap press while running; clear zeroes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lap_count <= '0;
            r_lap_valid <= 1'b0;
        end else if (w_press[BTN_CLR]) begin
            r_lap_count <= '0;
            r_lap_valid <= 1'b0;
        end else if (w_press[BTN_LAP] && (r_state == ST_RUN)) begin
            r_lap_count <= bus.count_in;
            r_lap_valid <= 1'b1;
        end else begin
            r_lap_valid <= 1'b0;
        end
    end

    assign bus.lap_count = r_lap_count;
    assign bus.lap_valid = r_lap_valid;
`endif

endmodule
`default_nettype wire
